// File: rtl/ofdm_sync_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ofdm_sync_pkg: shared state encodings, default widths and helpers for the |
// | OFDM sync scheduler.                          Revision: 1.0               |
// +---------------------------------------------------------------------------+
package ofdm_sync_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int METRIC_W_DEF = 32;
  localparam int LEN_W_DEF    = 16;
  localparam int STAT_W       = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLDOFF = 2'd3
  } sync_state_e;

  // Statistics stick at all-ones rather than wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_out_reg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sync_out_reg: single-entry registered output stage with valid/ready.      |
// |                                               Revision: 1.0               |
// +---------------------------------------------------------------------------+
module sync_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              o_tready,
  output logic [DATA_W-1:0] o_tdata,
  output logic              o_tlast,
  output logic              o_eob,
  output logic              o_tvalid,
  output logic              can_load
);

  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tlast_q, tlast_d;
  logic              eob_q, eob_d;
  logic              tvalid_q, tvalid_d;

  always_comb begin
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (clear) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end else if (load) begin
      tdata_d  = load_data;
      tlast_d  = load_last;
      tvalid_d = 1'b1;
    end else if (o_tready) begin
      tvalid_d = 1'b0;
    end
    eob_d = tlast_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      eob_q    <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      eob_q    <= eob_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign o_tdata  = tdata_q;
  assign o_tlast  = tlast_q;
  assign o_eob    = eob_q;
  assign o_tvalid = tvalid_q;
  assign can_load = !tvalid_q || o_tready;

endmodule
`default_nettype wire

// File: rtl/ofdm_sync_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ofdm_sync_scheduler: metric-threshold packet gating of a sample stream.   |
// | Optional statistics ports: define OFDM_SYNC_SCHED_STATS_EN. Revision: 1.0 |
// +---------------------------------------------------------------------------+
module ofdm_sync_scheduler
  import ofdm_sync_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int METRIC_W = METRIC_W_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                cfg_enable,
  input  logic [METRIC_W-1:0] cfg_threshold,
  input  logic [LEN_W-1:0]    cfg_packet_len,
  input  logic [LEN_W-1:0]    cfg_holdoff,
  input  logic [METRIC_W-1:0] m_tdata,
  input  logic                m_tvalid,
  output logic                m_tready,
  input  logic [DATA_W-1:0]   i_tdata,
  input  logic                i_tvalid,
  output logic                i_tready,
  output logic [DATA_W-1:0]   o_tdata,
  output logic                o_tlast,
  output logic                o_eob,
  output logic                o_tvalid,
  input  logic                o_tready,
  output logic [1:0]          state_o,
  output logic                cfg_busy
`ifdef OFDM_SYNC_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0]   det_count,
  output logic [STAT_W-1:0]   miss_count
`endif
);

  sync_state_e         state_q, state_d;
  logic [LEN_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [LEN_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [METRIC_W-1:0] sh_thr_q, sh_thr_d;
  logic [LEN_W-1:0]    sh_len_q, sh_len_d;
  logic [LEN_W-1:0]    sh_hold_q, sh_hold_d;
  logic                cfg_busy_q, cfg_busy_d;

  logic             out_ready, beat, over_thr, detect;
  logic             load, load_last, end_pkt, reload;
  logic [LEN_W-1:0] eff_len, pkt_next, hold_next;

  always_comb begin
    i_tready  = (state_q == ST_IDLE || state_q == ST_HOLDOFF) ? 1'b1 : out_ready;
    m_tready  = i_tready;
    beat      = i_tvalid && m_tvalid && i_tready;
    over_thr  = m_tdata > sh_thr_q;
    detect    = (state_q == ST_ARMED) && cfg_enable && beat && over_thr;
    // A zero-length packet still carries the detect sample.
    eff_len   = (sh_len_q == '0) ? LEN_W'(1) : sh_len_q;
    pkt_next  = pkt_cnt_q + LEN_W'(1);
    hold_next = hold_cnt_q + LEN_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    pkt_cnt_d  = pkt_cnt_q;
    hold_cnt_d = hold_cnt_q;
    sh_thr_d   = sh_thr_q;
    sh_len_d   = sh_len_q;
    sh_hold_d  = sh_hold_q;
    load       = 1'b0;
    load_last  = 1'b0;
    end_pkt    = 1'b0;
    reload     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_enable) begin
          state_d = ST_ARMED;
          reload  = 1'b1;
        end
      end
      ST_ARMED: begin
        if (!cfg_enable) begin
          state_d = ST_IDLE;
        end else if (detect) begin
          load      = 1'b1;
          pkt_cnt_d = LEN_W'(1);
          if (eff_len == LEN_W'(1)) begin
            load_last = 1'b1;
            end_pkt   = 1'b1;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        if (beat) begin
          load      = 1'b1;
          pkt_cnt_d = pkt_next;
          if (pkt_next >= eff_len) begin
            load_last = 1'b1;
            end_pkt   = 1'b1;
          end
        end
      end
      ST_HOLDOFF: begin
        if (!cfg_enable) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end else if (beat) begin
          hold_cnt_d = hold_next;
          if (hold_next >= sh_hold_q) begin
            state_d    = ST_ARMED;
            hold_cnt_d = '0;
            reload     = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable during a capture is honoured only once the packet closes.
    if (end_pkt) begin
      pkt_cnt_d  = '0;
      hold_cnt_d = '0;
      if (!cfg_enable) begin
        state_d = ST_IDLE;
      end else if (sh_hold_q == '0) begin
        state_d = ST_ARMED;
        reload  = 1'b1;
      end else begin
        state_d = ST_HOLDOFF;
      end
    end

    if (reload) begin
      sh_thr_d  = cfg_threshold;
      sh_len_d  = cfg_packet_len;
      sh_hold_d = cfg_holdoff;
    end

    cfg_busy_d = (state_d != ST_IDLE) && !reload;

    if (clear) begin
      state_d    = ST_IDLE;
      pkt_cnt_d  = '0;
      hold_cnt_d = '0;
      cfg_busy_d = 1'b0;
      load       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pkt_cnt_q  <= '0;
      hold_cnt_q <= '0;
      sh_thr_q   <= '0;
      sh_len_q   <= '0;
      sh_hold_q  <= '0;
      cfg_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_cnt_q  <= pkt_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      sh_thr_q   <= sh_thr_d;
      sh_len_q   <= sh_len_d;
      sh_hold_q  <= sh_hold_d;
      cfg_busy_q <= cfg_busy_d;
    end
  end

  assign state_o  = state_q;
  assign cfg_busy = cfg_busy_q;

  sync_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .load      (load),
    .load_data (i_tdata),
    .load_last (load_last),
    .o_tready  (o_tready),
    .o_tdata   (o_tdata),
    .o_tlast   (o_tlast),
    .o_eob     (o_eob),
    .o_tvalid  (o_tvalid),
    .can_load  (out_ready)
  );

`ifdef OFDM_SYNC_SCHED_STATS_EN
  logic [STAT_W-1:0] det_q, det_d, miss_q, miss_d;

  always_comb begin
    det_d  = det_q;
    miss_d = miss_q;
    if (clear) begin
      det_d  = '0;
      miss_d = '0;
    end else begin
      if (detect) det_d = sat_inc(det_q);
      if ((state_q == ST_CAPTURE || state_q == ST_HOLDOFF) && beat && over_thr)
        miss_d = sat_inc(miss_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      det_q  <= '0;
      miss_q <= '0;
    end else begin
      det_q  <= det_d;
      miss_q <= miss_d;
    end
  end

  assign det_count  = det_q;
  assign miss_count = miss_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ofdm_sync_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_ofdm_sync_scheduler: directed scoreboard bench for the sync scheduler. |
// |                                               Revision: 1.0               |
// +---------------------------------------------------------------------------+
module tb_ofdm_sync_scheduler;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        cfg_enable;
  logic [31:0] cfg_threshold;
  logic [15:0] cfg_packet_len;
  logic [15:0] cfg_holdoff;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] i_tdata;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_eob;
  logic        o_tvalid;
  logic        o_tready;
  logic [1:0]  state_o;
  logic        cfg_busy;
`ifdef OFDM_SYNC_SCHED_STATS_EN
  logic [31:0] det_count;
  logic [31:0] miss_count;
`endif

  ofdm_sync_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (clear),
    .cfg_enable     (cfg_enable),
    .cfg_threshold  (cfg_threshold),
    .cfg_packet_len (cfg_packet_len),
    .cfg_holdoff    (cfg_holdoff),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .i_tdata        (i_tdata),
    .i_tvalid       (i_tvalid),
    .i_tready       (i_tready),
    .o_tdata        (o_tdata),
    .o_tlast        (o_tlast),
    .o_eob          (o_eob),
    .o_tvalid       (o_tvalid),
    .o_tready       (o_tready),
    .state_o        (state_o),
    .cfg_busy       (cfg_busy)
`ifdef OFDM_SYNC_SCHED_STATS_EN
    ,
    .det_count      (det_count),
    .miss_count     (miss_count)
`endif
  );

  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAPT = 2'd2, S_HOLD = 2'd3;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic toggle_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic last);
    exp_t e;
    e.d = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // One beat: hold sample+metric until the DUT accepts them.
  task automatic beat(input logic [31:0] d, input logic [31:0] m);
    int cycles = 0;
    i_tdata = d; m_tdata = m; i_tvalid = 1'b1; m_tvalid = 1'b1;
    @(negedge clk);
    while (!i_tready && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    if (!i_tready) chk("beat_ready", i_tready, 1);
    @(posedge clk); #1;
    i_tvalid = 1'b0; m_tvalid = 1'b0;
  endtask

  task automatic drain();
    int cycles = 0;
    while ((exp_q.size() != 0 || o_tvalid) && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_idle", o_tvalid, 0);
    @(posedge clk); #1;
  endtask

  task automatic arm();
    cfg_enable = 1'b1;
    @(posedge clk); #1;
    chk("arm_state", state_o, S_ARMED);
  endtask

  task automatic reconfig(input logic [31:0] thr, input logic [15:0] len, input logic [15:0] hold);
    cfg_enable = 1'b0;
    @(posedge clk); #1;
    chk("disarm_state", state_o, S_IDLE);
    cfg_threshold = thr; cfg_packet_len = len; cfg_holdoff = hold;
    arm();
  endtask

  task automatic stop_toggle();
    toggle_en = 1'b0;
    @(posedge clk); #1;
    o_tready = 1'b1;
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (toggle_en) o_tready = ~o_tready;
  end

  // Output monitor: scoreboard pop on handshake, stability check on stall.
  logic        prev_stall = 1'b0, prev_clear = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0;
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (prev_stall && !prev_clear) begin
        chk("stall_valid", o_tvalid, 1);
        chk("stall_data", o_tdata, prev_data);
        chk("stall_last", o_tlast, prev_last);
      end
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_q", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", o_tdata, e.d);
          chk("out_tlast", o_tlast, e.last);
          chk("out_eob", o_eob, e.last);
        end
      end
    end
    prev_stall = reset_n && o_tvalid && !o_tready;
    prev_clear = clear;
    prev_data  = o_tdata;
    prev_last  = o_tlast;
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; cfg_enable = 1'b0;
    cfg_threshold = 32'd100; cfg_packet_len = 16'd4; cfg_holdoff = 16'd2;
    m_tdata = '0; m_tvalid = 1'b0; i_tdata = '0; i_tvalid = 1'b0; o_tready = 1'b1;
    #1;
    chk("rst_state", state_o, S_IDLE);
    chk("rst_tvalid", o_tvalid, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tlast", o_tlast, 0);
    chk("rst_eob", o_eob, 0);
    chk("rst_tdata", o_tdata, 0);
    chk("rst_busy", cfg_busy, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_hold", state_o, S_IDLE);

    // Basic packet: thr=100 len=4 holdoff=2, crossings in holdoff ignored.
    arm();
    beat(32'h1, 32'd50);
    chk("no_detect_50", state_o, S_ARMED);
    push(32'h2, 0); beat(32'h2, 32'd150);
    chk("detect_state", state_o, S_CAPT);
    push(32'h3, 0); beat(32'h3, 32'd0);
    push(32'h4, 0); beat(32'h4, 32'd0);
    push(32'h5, 1); beat(32'h5, 32'd0);
    chk("holdoff_entry", state_o, S_HOLD);
    beat(32'h6, 32'd500);
    chk("holdoff_1", state_o, S_HOLD);
    beat(32'h7, 32'd500);
    chk("holdoff_done", state_o, S_ARMED);
    drain();

    // Zero length behaves as one, holdoff 0 returns straight to ARMED.
    reconfig(32'd100, 16'd0, 16'd0);
    push(32'hA0, 1); beat(32'hA0, 32'd200);
    chk("len0_state", state_o, S_ARMED);
    beat(32'hA1, 32'd100);
    chk("thr_strict", state_o, S_ARMED);
    drain();

    // Backpressure: o_tready toggles during an 8-sample packet.
    reconfig(32'd100, 16'd8, 16'd0);
    toggle_en = 1'b1;
    push(32'h300, 0); beat(32'h300, 32'd101);
    for (int i = 1; i < 8; i++) begin
      push(32'h300 + i, (i == 7));
      beat(32'h300 + i, 32'd0);
    end
    drain();
    stop_toggle();

    // Length change mid-capture applies to the next packet only.
    reconfig(32'd100, 16'd4, 16'd1);
    push(32'h400, 0); beat(32'h400, 32'd150);
    push(32'h401, 0); beat(32'h401, 32'd0);
    cfg_packet_len = 16'd6;
    push(32'h402, 0); beat(32'h402, 32'd0);
    push(32'h403, 1); beat(32'h403, 32'd0);
    chk("len_change_hold", state_o, S_HOLD);
    beat(32'h404, 32'd0);
    chk("len_change_arm", state_o, S_ARMED);
    for (int i = 0; i < 6; i++) begin
      push(32'h410 + i, (i == 5));
      beat(32'h410 + i, (i == 0) ? 32'd150 : 32'd0);
    end
    chk("len6_hold", state_o, S_HOLD);
    beat(32'h416, 32'd0);
    drain();

    // Disable at sample 2 of 4: packet completes, then IDLE.
    reconfig(32'd100, 16'd4, 16'd2);
    push(32'h500, 0); beat(32'h500, 32'd150);
    push(32'h501, 0); beat(32'h501, 32'd0);
    cfg_enable = 1'b0;
    push(32'h502, 0); beat(32'h502, 32'd0);
    chk("dis_capture", state_o, S_CAPT);
    push(32'h503, 1); beat(32'h503, 32'd0);
    chk("dis_idle", state_o, S_IDLE);
    beat(32'h504, 32'd999);
    chk("idle_drop", state_o, S_IDLE);
    drain();

    // Clear at sample 2: pending output abandoned.
    arm();
    push(32'h510, 0); beat(32'h510, 32'd150);
    beat(32'h511, 32'd0);
    o_tready = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_tvalid", o_tvalid, 0);
    chk("clear_state", state_o, S_IDLE);
    o_tready = 1'b1;
    @(posedge clk); #1;
    chk("clear_rearm", state_o, S_ARMED);
    drain();

    // Statistics: 3 detects, 5 crossings during capture/holdoff.
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 6; k++) begin
        logic [31:0] m;
        m = 32'd0;
        if (k == 0) m = 32'd150;
        if (p == 0 && (k == 1 || k == 2 || k == 4)) m = 32'd200;
        if (p == 1 && k == 1) m = 32'd200;
        if (p == 2 && k == 2) m = 32'd200;
        if (k < 4) push(32'h600 + 16 * p + k, (k == 3));
        beat(32'h600 + 16 * p + k, m);
      end
      chk("stats_pkt_arm", state_o, S_ARMED);
    end
    drain();
`ifdef OFDM_SYNC_SCHED_STATS_EN
    chk("det_count", det_count, 3);
    chk("miss_count", miss_count, 5);
`endif

    // Asynchronous reset mid-capture clears outputs without a clock edge.
    push(32'h700, 0); beat(32'h700, 32'd150);
    beat(32'h701, 32'd0);
    chk("pre_rst_valid", o_tvalid, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_tvalid", o_tvalid, 0);
    chk("arst_tlast", o_tlast, 0);
    chk("arst_eob", o_eob, 0);
    chk("arst_tdata", o_tdata, 0);
    chk("arst_state", state_o, S_IDLE);
    chk("arst_busy", cfg_busy, 0);
`ifdef OFDM_SYNC_SCHED_STATS_EN
    chk("arst_det", det_count, 0);
    chk("arst_miss", miss_count, 0);
`endif
    chk("arst_queue", exp_q.size(), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("post_rst_idle", state_o, S_IDLE);
    @(posedge clk); #1;
    chk("post_rst_arm", state_o, S_ARMED);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ofdm_sync_scheduler.md
OFDM_SYNC_SCHEDULER -- requirements
Module: ofdm_sync_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning sample width (packed sc16 I/Q).
REQ-002 SHALL have parameter METRIC_W, default 32, meaning unsigned timing-metric width.
REQ-003 SHALL have parameter LEN_W, default 16, meaning width of packet-length and holdoff counters.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  block clock; reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port clear  in  1  synchronous soft reset of internal state only.
REQ-006 SHALL have ports cfg_enable  in  1;  cfg_threshold  in  METRIC_W;  cfg_packet_len  in  LEN_W;  cfg_holdoff  in  LEN_W.
REQ-007 SHALL have ports m_tdata  in  METRIC_W;  m_tvalid  in  1;  m_tready  out  1.  These carry the metric, sample-aligned with i_*.
REQ-008 SHALL have ports i_tdata  in  DATA_W;  i_tvalid  in  1;  i_tready  out  1.  These carry the delayed sample stream.
REQ-009 SHALL have ports o_tdata  out  DATA_W;  o_tlast  out  1;  o_eob  out  1;  o_tvalid  out  1;  o_tready  in  1.
REQ-010 SHALL have ports state_o  out  2  (current state encoding) and cfg_busy  out  1  (high when shadow config is not being reloaded).

Function
REQ-011 SHALL define a beat as i_tvalid & m_tvalid & i_tready; m_tready SHALL equal i_tready; one sample and one metric SHALL be consumed per beat.
REQ-012 SHALL drive i_tready = 1 in IDLE and HOLDOFF, and i_tready = (!o_tvalid | o_tready) in ARMED and CAPTURE.
REQ-013 SHALL implement states IDLE=0, ARMED=1, CAPTURE=2, HOLDOFF=3.
REQ-014 SHALL, when entering ARMED, latch cfg_threshold, cfg_packet_len and cfg_holdoff into shadow registers; cfg changes at other times SHALL NOT affect an ongoing capture.
REQ-015 SHALL transition IDLE->ARMED on the first cycle with cfg_enable=1.
REQ-016 SHALL detect on an ARMED beat with m_tdata > shadow threshold (unsigned, strict); that beat's sample SHALL be the first output sample; state SHALL go to CAPTURE with sample count 1.
REQ-017 SHALL register the output: o_tvalid rises the cycle after the loading beat (latency 1); o_* SHALL hold stable while o_tvalid & !o_tready.
REQ-018 SHALL forward each CAPTURE beat; on the beat that makes the count equal to shadow length, it SHALL set o_tlast=o_eob=1 and go to HOLDOFF (or ARMED if shadow holdoff=0).
REQ-019 SHALL treat shadow length 0 as 1: the detect sample is emitted with o_tlast=o_eob=1.
REQ-020 SHALL drop (consume, not forward) samples in IDLE, ARMED (non-detect) and HOLDOFF.
REQ-021 SHALL count HOLDOFF beats and enter ARMED after exactly shadow holdoff beats; metric crossings during HOLDOFF SHALL be ignored.
REQ-022 SHALL, on cfg_enable=0, go ARMED->IDLE and HOLDOFF->IDLE immediately; CAPTURE SHALL complete its packet, then go to IDLE.
REQ-023 SHALL, on clear=1, go to IDLE, zero the counters and deassert o_tvalid in the next cycle; a partially sent packet is abandoned without tlast.

Reset
REQ-024 SHALL, while reset_n=0, hold state=IDLE, counters=0, o_tvalid=o_tlast=o_eob=0, o_tdata=0, shadows = 0, cfg_busy=0, statistics=0.

Configuration
REQ-025 SHALL, with macro OFDM_SYNC_SCHED_STATS_EN defined, add outputs det_count (32 bits, increments per detect) and miss_count (32 bits, increments per metric>threshold beat in CAPTURE or HOLDOFF), both saturating and reset by reset_n/clear; without the macro, these ports and their logic SHALL be absent.

Structure
REQ-026 SHALL place the state enum, state encodings and default widths in the package ofdm_sync_pkg.
REQ-027 SHALL implement the output register/handshake as sub-module sync_out_reg; the FSM and counters SHALL stay in the top level.

Verification
REQ-028 Bench SHALL check: enable=1, thr=100, len=4, holdoff=2, metric 50,150,0,0,0 -> samples 1..4 of the stream from the 150 beat are output, tlast/eob only on the 4th, then 2 beats are dropped, then state=ARMED.
REQ-029 Bench SHALL check: len=0, metric=200>thr=100 -> single output with tlast=eob=1.
REQ-030 Bench SHALL check: o_tready toggling 50% during a len=8 capture -> 8 ordered samples, o_* stable while stalled, no drop.
REQ-031 Bench SHALL check: cfg_packet_len 4->6 mid-capture -> current packet still 4; next packet 6.
REQ-032 Bench SHALL check: cfg_enable=0 at capture sample 2 of 4 -> samples 3,4 still sent, then IDLE; clear at sample 2 -> o_tvalid=0 next cycle, IDLE.
REQ-033 Bench SHALL check: with OFDM_SYNC_SCHED_STATS_EN, 3 detects and 5 crossings during capture -> det_count=3, miss_count=5; async reset_n pulse mid-capture -> all outputs 0 immediately.
